// File: rtl/if_stage_pkg.sv
// ============================================================================
//  Module      : if_stage_pkg
//  Description : Shared widths, reset PC and IF state type for the fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package if_stage_pkg;

    localparam int          c_FS_TO_DS_BUS_WD = 64;
    localparam int          c_BR_BUS_WD       = 33;
    localparam logic [31:0] c_RESET_PC        = 32'h1c00_0000;

    typedef enum logic [1:0] {
        FS_EMPTY = 2'd0,
        FS_WAIT  = 2'd1,
        FS_HOLD  = 2'd2
    } fs_state_e;

    // Sequential successor; wraps modulo 2^32 by construction.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
//  Module      : if_stage
//  Description : Pre-IF PC generation and IF stage; one outstanding fetch on
//                an SRAM-like port, single-entry instruction slot to id_stage.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         ds_allowin,
    input  logic [c_BR_BUS_WD-1:0]       br_bus,
    output logic                         fs_to_ds_valid,
    output logic [c_FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                         inst_sram_req,
    output logic                         inst_sram_wr,
    output logic [1:0]                   inst_sram_size,
    output logic [3:0]                   inst_sram_wstrb,
    output logic [31:0]                  inst_sram_addr,
    output logic [31:0]                  inst_sram_wdata,
    input  logic                         inst_sram_addr_ok,
    input  logic                         inst_sram_data_ok,
    input  logic [31:0]                  inst_sram_rdata
);

    fs_state_e   r_state;
    fs_state_e   w_state_next;

    logic        r_discard;
    logic        r_br_buf_valid;
    logic [31:0] r_br_buf_pc;
    logic [31:0] r_last_pc;
    logic [31:0] r_hold_inst;
    logic [31:0] r_hold_pc;

    logic        w_br_taken;
    logic [31:0] w_br_target;
    logic        w_br_ev;
    logic [31:0] w_next_pc;
    logic        w_outstanding;
    logic        w_holding;
    logic        w_fetch_done;
    logic        w_fetch_live;
    logic        w_slot_busy;
    logic        w_fs_valid;
    logic        w_req;
    logic        w_accept;
    logic        w_latch_hold;
    logic        w_discard_next;

    assign w_br_taken  = br_bus[32];
    assign w_br_target = br_bus[31:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= FS_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_br_ev        = w_br_taken & ds_allowin;
        w_outstanding  = (r_state == FS_WAIT);
        w_holding      = (r_state == FS_HOLD);
        w_fetch_done   = w_outstanding & inst_sram_data_ok;
        w_fetch_live   = w_fetch_done & ~r_discard;
        w_slot_busy    = w_holding | w_fetch_live;
        // A taken branch flushes whatever sits in the slot this cycle.
        w_fs_valid     = w_slot_busy & ~w_br_ev;

        if (w_br_ev) begin
            w_next_pc = w_br_target;
        end else if (r_br_buf_valid) begin
            w_next_pc = r_br_buf_pc;
        end else begin
            w_next_pc = seq_pc(r_last_pc);
        end

        // A discarded return frees the outstanding slot just as a live one does.
        w_req          = resetn
                       & (~w_outstanding | w_fetch_done)
                       & (~w_slot_busy | (w_fs_valid & ds_allowin) | w_br_ev);
        w_accept       = w_req & inst_sram_addr_ok;
        w_latch_hold   = w_fetch_live & w_fs_valid & ~ds_allowin;
        w_discard_next = w_outstanding & ~inst_sram_data_ok & (r_discard | w_br_ev);

        if (w_accept) begin
            w_state_next = FS_WAIT;
        end else if (w_outstanding & ~inst_sram_data_ok) begin
            w_state_next = FS_WAIT;
        end else if (w_fs_valid & ~ds_allowin) begin
            w_state_next = FS_HOLD;
        end else begin
            w_state_next = FS_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last_pc      <= RESET_PC - 32'd4;
            r_discard      <= 1'b0;
            r_br_buf_valid <= 1'b0;
            r_br_buf_pc    <= 32'd0;
            r_hold_inst    <= 32'd0;
            r_hold_pc      <= 32'd0;
        end else begin
            r_discard <= w_discard_next;

            if (w_accept) begin
                r_last_pc      <= w_next_pc;
                r_br_buf_valid <= 1'b0;
            end else if (w_br_ev) begin
                r_br_buf_valid <= 1'b1;
                r_br_buf_pc    <= w_br_target;
            end

            // r_last_pc doubles as the pc of the in-flight fetch.
            if (w_latch_hold) begin
                r_hold_inst <= inst_sram_rdata;
                r_hold_pc   <= r_last_pc;
            end
        end
    end

    assign fs_to_ds_valid  = w_fs_valid;
    assign fs_to_ds_bus    = w_holding ? {r_hold_inst, r_hold_pc}
                                       : {inst_sram_rdata, r_last_pc};
    assign inst_sram_req   = w_req;
    assign inst_sram_addr  = w_next_pc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'd0;
    assign inst_sram_wdata = 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
//  Module      : tb_if_stage
//  Description : Randomized scoreboard bench for if_stage against a program-
//                order PC-stream model and a one-deep instruction memory model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    localparam logic [31:0] c_RESET_PC = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ds_allowin;
    logic [32:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    logic        br_taken_drv;
    logic [31:0] br_target_drv;

    assign br_bus = {br_taken_drv, br_target_drv};

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(c_RESET_PC)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ds_allowin        (ds_allowin),
        .br_bus            (br_bus),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_bus      (fs_to_ds_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          xfers  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] pend_q[$];
    logic [31:0] last_pushed;
    logic        prev_stalled = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0280_0421;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected delivery stream: program order from the last redirect.
    task automatic refill();
        while (exp_q.size() < 4) begin
            last_pushed = last_pushed + 32'd4;
            exp_q.push_back(last_pushed);
        end
    endtask

    task automatic restart_stream(input logic [31:0] pc);
        exp_q.delete();
        exp_q.push_back(pc);
        last_pushed = pc;
        refill();
    endtask

    // Monitor and memory bookkeeping, mid-cycle.
    always @(negedge clk) begin
        if (resetn) begin
            if (br_taken_drv && ds_allowin)
                chk("valid_on_flush", {63'd0, fs_to_ds_valid}, 64'd0);
            else if (prev_stalled)
                chk("held_valid", {63'd0, fs_to_ds_valid}, 64'd1);

            if (pend_q.size() != 0 && !inst_sram_data_ok)
                chk("one_outstanding_req", {63'd0, inst_sram_req}, 64'd0);
            if (fs_to_ds_valid && !ds_allowin)
                chk("req_while_held", {63'd0, inst_sram_req}, 64'd0);

            if (fs_to_ds_valid) begin
                if (exp_q.size() == 0) begin
                    chk("exp_q_empty", {63'd0, fs_to_ds_valid}, 64'd0);
                end else begin
                    chk("pc", {32'd0, fs_to_ds_bus[31:0]}, {32'd0, exp_q[0]});
                    chk("inst", {32'd0, fs_to_ds_bus[63:32]}, {32'd0, mem_word(exp_q[0])});
                    if (ds_allowin) begin
                        void'(exp_q.pop_front());
                        xfers++;
                    end
                end
            end
            prev_stalled = fs_to_ds_valid & ~ds_allowin;

            if (inst_sram_data_ok && pend_q.size() != 0)
                void'(pend_q.pop_front());
            if (inst_sram_req && inst_sram_addr_ok)
                pend_q.push_back(inst_sram_addr);
        end
    end

    task automatic drive_cycle(input bit ideal);
        int sel;
        if (ideal) begin
            inst_sram_addr_ok = 1'b1;
            inst_sram_data_ok = (pend_q.size() != 0);
            ds_allowin        = 1'b1;
            br_taken_drv      = 1'b0;
            br_target_drv     = $urandom();
        end else begin
            inst_sram_addr_ok = ($urandom_range(0, 99) < 70);
            inst_sram_data_ok = (pend_q.size() != 0) && ($urandom_range(0, 99) < 60);
            ds_allowin        = ($urandom_range(0, 99) < 75);
            if (!br_taken_drv) begin
                br_target_drv = $urandom();
                if ($urandom_range(0, 99) < 6) begin
                    br_taken_drv = 1'b1;
                    sel = $urandom_range(0, 2);
                    br_target_drv = (sel == 0) ? 32'h1c00_0100 :
                                    (sel == 1) ? 32'hffff_fff8 :
                                                 ($urandom() & 32'hffff_fffc);
                end
            end
        end
        inst_sram_rdata = inst_sram_data_ok ? mem_word(pend_q[0]) : $urandom();
        if (br_taken_drv && ds_allowin)
            restart_stream(br_target_drv);
        refill();
    endtask

    initial begin
        int x5;
        bit did_reset;
        bit br_fired;

        resetn            = 1'b0;
        ds_allowin        = 1'b0;
        br_taken_drv      = 1'b0;
        br_target_drv     = 32'd0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'd0;
        x5                = 0;
        did_reset         = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, fs_to_ds_valid}, 64'd0);
        chk("rst_req", {63'd0, inst_sram_req}, 64'd0);
        chk("wr", {63'd0, inst_sram_wr}, 64'd0);
        chk("size", {62'd0, inst_sram_size}, 64'd2);
        chk("wstrb", {60'd0, inst_sram_wstrb}, 64'd0);
        chk("wdata", {32'd0, inst_sram_wdata}, 64'd0);

        restart_stream(c_RESET_PC);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        drive_cycle(1'b1);
        #1;
        chk("first_req", {63'd0, inst_sram_req}, 64'd1);
        chk("first_addr", {32'd0, inst_sram_addr}, {32'd0, c_RESET_PC});

        for (int i = 1; i < 20; i++) begin
            @(posedge clk);
            #1;
            drive_cycle(1'b1);
            if (i == 5)  x5 = xfers;
            if (i == 15) chk("throughput_10cyc", 64'(xfers - x5), 64'd10);
        end

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (br_taken_drv && ds_allowin) br_taken_drv = 1'b0;
            if (!resetn) resetn = 1'b1;
            drive_cycle(1'b0);
            br_fired = br_taken_drv && ds_allowin;
            if (i >= 1500 && !did_reset && pend_q.size() != 0 && !br_fired) begin
                did_reset = 1'b1;
                #2;
                resetn = 1'b0;
                #1;
                chk("midrst_valid", {63'd0, fs_to_ds_valid}, 64'd0);
                chk("midrst_req", {63'd0, inst_sram_req}, 64'd0);
                pend_q.delete();
                br_taken_drv      = 1'b0;
                inst_sram_data_ok = 1'b0;
                inst_sram_addr_ok = 1'b0;
                prev_stalled      = 1'b0;
                restart_stream(c_RESET_PC);
            end
        end

        chk("did_mid_reset", {63'd0, did_reset}, 64'd1);
        chk("xfers_min", {63'd0, (xfers >= 300)}, 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
